// File: rtl/apb_rx_ctrl.sv
// UART receive control: line synchroniser, start-bit qualification, baud timing and shadow frame assembly.
// Optional parity stage is compiled in when RX_PARITY_EN is defined.
module apb_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sel,
    input  logic       rx_en,
    input  logic       rx_in,
`ifdef RX_PARITY_EN
    input  logic       parity_odd,
    output logic       parity_err,
`endif
    output logic       start_bit,
    output logic       end_bit,
    output logic [9:0] data_bit,
    output logic [9:0] bit_cnto,
    output logic       sample_stb,
    output logic [9:0] rx_shift,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [9:0] CNT_LAST = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] CNT_HALF = 10'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] IDX_LAST = 4'(DATA_BITS - 1);

    state_e     state_q, state_d;
    logic       rx_m_q, rx_s_q, rx_d_q;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [9:0] shift_q, shift_d;
    logic       start_bit_q, start_bit_d;
    logic       end_bit_q, end_bit_d;
    logic [9:0] data_bit_q, data_bit_d;
    logic       sample_stb_q, sample_stb_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       rx_busy_q, rx_busy_d;
`ifdef RX_PARITY_EN
    logic       par_bad_q, par_bad_d;
    logic       parity_err_q, parity_err_d;
`endif

    logic active;
    logic cnt_last;

    assign active   = sel & rx_en;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        sample_stb_d = 1'b0;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (!active) begin
            // Shadow data is kept across a disable so software can still read it.
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (rx_d_q && !rx_s_q) begin
                        state_d = S_START;
                        shift_d = '0;
`ifdef RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        sample_stb_d = 1'b1;
                        cnt_d        = '0;
                        idx_d        = '0;
                        state_d      = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_last) begin
                        sample_stb_d   = 1'b1;
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s_q;
                        if (idx_q == IDX_LAST) begin
`ifdef RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_last) begin
                        // Bits above DATA_BITS are always zero, so a full-width XOR is safe.
                        sample_stb_d = 1'b1;
                        cnt_d        = '0;
                        par_bad_d    = ((^shift_q) ^ rx_s_q) != parity_odd;
                        state_d      = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_last) begin
                        sample_stb_d = 1'b1;
                        cnt_d        = '0;
                        rx_valid_d   = rx_s_q;
                        frame_err_d  = !rx_s_q;
`ifdef RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Status outputs follow the next state so they move on the same edge as the FSM.
        start_bit_d = (state_d == S_START);
        end_bit_d   = (state_d == S_STOP);
        data_bit_d  = (state_d == S_DATA) ? 10'(idx_d) : 10'h3FF;
        rx_busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_d_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            start_bit_q  <= 1'b0;
            end_bit_q    <= 1'b0;
            data_bit_q   <= 10'h3FF;
            sample_stb_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_m_q       <= rx_in;
            rx_s_q       <= rx_m_q;
            rx_d_q       <= rx_s_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            start_bit_q  <= start_bit_d;
            end_bit_q    <= end_bit_d;
            data_bit_q   <= data_bit_d;
            sample_stb_q <= sample_stb_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
`ifdef RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign start_bit  = start_bit_q;
    assign end_bit    = end_bit_q;
    assign data_bit   = data_bit_q;
    assign bit_cnto   = cnt_q;
    assign sample_stb = sample_stb_q;
    assign rx_shift   = shift_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;
`ifdef RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
